// File: rtl/bg_tile_fetch_seq.sv
`default_nettype none
// ============================================================================
// bg_tile_fetch_seq : per-scanline background tile fetcher (NT/AT/PT via req/ack)
// Revision : 1.0
// ============================================================================
module bg_tile_fetch_seq #(
  parameter int TILES_PER_LINE = 33,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [8:0]        line_y,
  input  logic [7:0]        scroll_x,
  input  logic [7:0]        scroll_y,
  input  logic [1:0]        nt_sel,
  input  logic              pt_base,
  input  logic [2:0]        mirror_mode,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic [7:0]        tile_nt,
  output logic [7:0]        tile_pt_lo,
  output logic [7:0]        tile_pt_hi,
  output logic [1:0]        tile_attr,
  output logic [2:0]        fine_x,
  output logic              busy,
  output logic              line_done,
  output logic              overrun
);

  localparam int T_W = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;
  localparam logic [T_W-1:0] c_T_LAST = T_W'(TILES_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NT   = 3'd1,
    S_AT   = 3'd2,
    S_PTL  = 3'd3,
    S_PTH  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [T_W-1:0]  r_t;
  logic [4:0]      r_coarse_x;
  logic            r_nt_x;
  logic [7:0]      r_ry;
  logic            r_vy_hi;
  logic            r_pt_base;
  logic [2:0]      r_mirror;
  logic [7:0]      r_tile_nt;
  logic [7:0]      r_tile_pt_lo;
  logic [7:0]      r_tile_pt_hi;
  logic [1:0]      r_tile_attr;
  logic [2:0]      r_fine_x;
  logic            r_line_done;
  logic            r_overrun;

  logic [10:0]     w_vy_sum;
  logic [10:0]     w_vy;
  logic            w_vy_hi;
  logic [7:0]      w_ry;
  logic [5:0]      w_xt;
  logic [4:0]      w_r;
  logic [4:0]      w_c;
  logic [1:0]      w_ln;
  logic [1:0]      w_p;
  logic [15:0]     w_addr;
  logic [1:0]      w_attr;
  logic            w_start;
  logic            w_accept;

  assign w_start  = line_start && (r_state == S_IDLE);
  assign w_accept = (r_state == S_OUT) && tile_ready;

  // Vertical position is fixed for the whole line, so it is resolved once at line_start.
  always_comb begin
    w_vy_sum = {2'b00, line_y} + {3'b000, scroll_y} + (nt_sel[1] ? 11'd240 : 11'd0);
    if (w_vy_sum >= 11'd960)
      w_vy = w_vy_sum - 11'd960;
    else if (w_vy_sum >= 11'd480)
      w_vy = w_vy_sum - 11'd480;
    else
      w_vy = w_vy_sum;
    w_vy_hi = (w_vy >= 11'd240);
    w_ry    = w_vy_hi ? 8'(w_vy - 11'd240) : 8'(w_vy);
  end

  // Fine X bits never carry into the tile column, so only x[8:3] is tracked.
  assign w_xt = {r_nt_x, r_coarse_x} + 6'(r_t);
  assign w_r  = r_ry[7:3];
  assign w_c  = w_xt[4:0];
  assign w_ln = {r_vy_hi, w_xt[5]};

  always_comb begin
    case (r_mirror)
      3'd1:    w_p = {1'b0, w_ln[1]};
      3'd2:    w_p = 2'd0;
      3'd3:    w_p = 2'd1;
      3'd4:    w_p = w_ln;
      default: w_p = {1'b0, w_ln[0]};
    endcase
  end

  always_comb begin
    w_addr = 16'h0000;
    case (r_state)
      S_NT:    w_addr = {4'b0010, w_p, w_r, w_c};
      S_AT:    w_addr = {4'b0010, w_p, 4'b1111, w_r[4:2], w_c[4:2]};
      S_PTL:   w_addr = {3'b000, r_pt_base, r_tile_nt, 1'b0, r_ry[2:0]};
      S_PTH:   w_addr = {3'b000, r_pt_base, r_tile_nt, 1'b1, r_ry[2:0]};
      default: w_addr = 16'h0000;
    endcase
  end

  always_comb begin
    case ({w_r[1], w_c[1]})
      2'd0:    w_attr = mem_rdata[1:0];
      2'd1:    w_attr = mem_rdata[3:2];
      2'd2:    w_attr = mem_rdata[5:4];
      default: w_attr = mem_rdata[7:6];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (line_start) w_state_nxt = S_NT;
      S_NT:    if (mem_ack)    w_state_nxt = S_AT;
      S_AT:    if (mem_ack)    w_state_nxt = S_PTL;
      S_PTL:   if (mem_ack)    w_state_nxt = S_PTH;
      S_PTH:   if (mem_ack)    w_state_nxt = S_OUT;
      S_OUT:   if (tile_ready) w_state_nxt = (r_t == c_T_LAST) ? S_IDLE : S_NT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t          <= '0;
      r_coarse_x   <= '0;
      r_nt_x       <= 1'b0;
      r_ry         <= '0;
      r_vy_hi      <= 1'b0;
      r_pt_base    <= 1'b0;
      r_mirror     <= '0;
      r_tile_nt    <= '0;
      r_tile_pt_lo <= '0;
      r_tile_pt_hi <= '0;
      r_tile_attr  <= '0;
      r_fine_x     <= '0;
      r_line_done  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      if (w_start) begin
        r_t        <= '0;
        r_coarse_x <= scroll_x[7:3];
        r_fine_x   <= scroll_x[2:0];
        r_nt_x     <= nt_sel[0];
        r_ry       <= w_ry;
        r_vy_hi    <= w_vy_hi;
        r_pt_base  <= pt_base;
        r_mirror   <= mirror_mode;
        r_overrun  <= 1'b0;
      end else if (line_start) begin
        r_overrun <= 1'b1;
      end
      if (mem_ack) begin
        case (r_state)
          S_NT:    r_tile_nt    <= mem_rdata;
          S_AT:    r_tile_attr  <= w_attr;
          S_PTL:   r_tile_pt_lo <= mem_rdata;
          S_PTH:   r_tile_pt_hi <= mem_rdata;
          default: ;
        endcase
      end
      if (w_accept) begin
        if (r_t == c_T_LAST)
          r_line_done <= 1'b1;
        else
          r_t <= r_t + T_W'(1);
      end
    end
  end

  assign mem_req    = (r_state == S_NT) || (r_state == S_AT) ||
                      (r_state == S_PTL) || (r_state == S_PTH);
  assign mem_addr   = ADDR_W'(w_addr);
  assign tile_valid = (r_state == S_OUT);
  assign tile_nt    = r_tile_nt;
  assign tile_pt_lo = r_tile_pt_lo;
  assign tile_pt_hi = r_tile_pt_hi;
  assign tile_attr  = r_tile_attr;
  assign fine_x     = r_fine_x;
  assign busy       = (r_state != S_IDLE);
  assign line_done  = r_line_done;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_bg_tile_fetch_seq.sv
`default_nettype none
// ============================================================================
// tb_bg_tile_fetch_seq : directed self-checking bench for bg_tile_fetch_seq
// Revision : 1.0
// ============================================================================
module tb_bg_tile_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [8:0]  line_y;
  logic [7:0]  scroll_x;
  logic [7:0]  scroll_y;
  logic [1:0]  nt_sel;
  logic        pt_base;
  logic [2:0]  mirror_mode;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        tile_valid;
  logic        tile_ready;
  logic [7:0]  tile_nt;
  logic [7:0]  tile_pt_lo;
  logic [7:0]  tile_pt_hi;
  logic [1:0]  tile_attr;
  logic [2:0]  fine_x;
  logic        busy;
  logic        line_done;
  logic        overrun;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int c0    = 0;

  bg_tile_fetch_seq #(.TILES_PER_LINE(33), .ADDR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .line_start  (line_start),
    .line_y      (line_y),
    .scroll_x    (scroll_x),
    .scroll_y    (scroll_y),
    .nt_sel      (nt_sel),
    .pt_base     (pt_base),
    .mirror_mode (mirror_mode),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .tile_valid  (tile_valid),
    .tile_ready  (tile_ready),
    .tile_nt     (tile_nt),
    .tile_pt_lo  (tile_pt_lo),
    .tile_pt_hi  (tile_pt_hi),
    .tile_attr   (tile_attr),
    .fine_x      (fine_x),
    .busy        (busy),
    .line_done   (line_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a line_start, then scramble the inputs so later fetches prove they were latched.
  task automatic start_line(input logic [8:0] ly, input logic [7:0] sx, input logic [7:0] sy,
                            input logic [1:0] ns, input logic pb, input logic [2:0] mm);
    line_y = ly; scroll_x = sx; scroll_y = sy; nt_sel = ns; pt_base = pb; mirror_mode = mm;
    line_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    line_start = 1'b0;
    line_y = 9'd100; scroll_x = 8'hA5; scroll_y = 8'h3C; nt_sel = 2'b11;
    pt_base = ~pb; mirror_mode = 3'd3;
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic fetch(input string tag, input logic [15:0] a, input logic [7:0] d, input int dly);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(mem_req), 1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 32'({mem_req, mem_addr}), 32'({1'b1, a}));
    end
    mem_ack = 1'b1;
    mem_rdata = d;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
  endtask

  task automatic take(input string tag, input logic [7:0] nt, input logic [7:0] pl,
                      input logic [7:0] ph, input logic [1:0] at, input int stall);
    int n;
    n = 0;
    while (tile_valid !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(tile_valid), 1);
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) tile_ready = 1'b1;
      chk({tag, "_rec"},
          32'({mem_req, tile_valid, tile_nt, tile_pt_lo, tile_pt_hi, tile_attr}),
          32'({1'b0, 1'b1, nt, pl, ph, at}));
      @(negedge clk);
    end
    tile_ready = 1'b0;
  endtask

  task automatic do_tile(input string tag, input logic [15:0] a_nt, input logic [15:0] a_at,
                         input logic [15:0] a_pl, input logic [7:0] d_nt, input logic [7:0] d_at,
                         input logic [7:0] d_pl, input logic [7:0] d_ph, input logic [1:0] e_attr,
                         input int dly, input int stall);
    fetch({tag, "_nt"}, a_nt, d_nt, dly);
    fetch({tag, "_at"}, a_at, d_at, dly);
    fetch({tag, "_ptl"}, a_pl, d_pl, dly);
    fetch({tag, "_pth"}, 16'(a_pl + 16'h0008), d_ph, dly);
    take(tag, d_nt, d_pl, d_ph, e_attr, stall);
  endtask

  task automatic abort_line();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", 32'({busy, mem_req, tile_valid}), 0);
  endtask

  initial begin
    logic [7:0]  nt;
    logic [15:0] ant;
    logic [15:0] aat;
    logic [1:0]  eat;

    rst = 1'b1; line_start = 1'b0; line_y = '0; scroll_x = '0; scroll_y = '0;
    nt_sel = '0; pt_base = 1'b0; mirror_mode = '0; mem_ack = 1'b0; mem_rdata = '0;
    tile_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'({mem_req, mem_addr, tile_valid, busy, line_done, overrun, fine_x}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 32'({mem_req, busy, tile_valid}), 0);

    // Line A: zero scroll, vertical mirroring, zero-wait memory, ready always given.
    start_line(9'd0, 8'd0, 8'd0, 2'd0, 1'b0, 3'd0);
    for (int t = 0; t < 33; t++) begin
      nt  = 8'(8'h41 + t);
      ant = (t < 32) ? 16'(16'h2000 + t) : 16'h2400;
      aat = (t < 32) ? 16'(16'h23C0 + t / 4) : 16'h27C0;
      eat = (t < 32 && ((t >> 1) & 1) == 1) ? 2'd1 : 2'd0;
      do_tile("a", ant, aat, 16'({nt, 4'h0}), nt, 8'hE4, 8'(t), 8'(8'h5A ^ t), eat, 0, 0);
    end
    chk("a_done_cycle", 32'(cyc - c0), 166);
    chk("a_done", 32'({line_done, busy, fine_x}), 32'({1'b1, 1'b0, 3'd0}));

    // Horizontal mirroring, vy = 247; started in the line_done cycle.
    start_line(9'd239, 8'd0, 8'd8, 2'd0, 1'b0, 3'd1);
    chk("done_pulse", 32'(line_done), 0);
    do_tile("h", 16'h2400, 16'h27C0, 16'h0337, 8'h33, 8'hC0, 8'h11, 8'h22, 2'd0, 0, 0);
    abort_line();

    // Same inputs, vertical mirroring.
    start_line(9'd239, 8'd0, 8'd8, 2'd0, 1'b0, 3'd0);
    do_tile("v", 16'h2000, 16'h23C0, 16'h0337, 8'h33, 8'hC0, 8'h44, 8'h66, 2'd0, 0, 0);
    abort_line();

    // Four-screen, nt_sel 2, scroll_y 255: vy wraps to 254.
    start_line(9'd239, 8'd5, 8'd255, 2'd2, 1'b0, 3'd4);
    do_tile("q", 16'h2820, 16'h2BC0, 16'h0126, 8'h12, 8'hE4, 8'h9C, 8'h3D, 2'd0, 1, 1);
    chk("q_fine_x", 32'(fine_x), 5);
    abort_line();

    // Line B: row 2, pattern table 1, attribute 0xC0, random ack delays and stalls.
    start_line(9'd16, 8'd0, 8'd0, 2'd0, 1'b1, 3'd0);
    for (int t = 0; t < 33; t++) begin
      nt  = 8'(8'h80 + t);
      ant = (t < 32) ? 16'(16'h2040 + t) : 16'h2440;
      aat = (t < 32) ? 16'(16'h23C0 + t / 4) : 16'h27C0;
      eat = (t < 32 && ((t >> 1) & 1) == 1) ? 2'd3 : 2'd0;
      do_tile("b", ant, aat, 16'(16'h1000 + {nt, 4'h0}), nt, 8'hC0, 8'(8'hF0 ^ t),
              8'(8'h0F + t), eat, int'($urandom_range(3)), int'($urandom_range(2)));
    end
    chk("b_done", 32'({line_done, busy}), 32'(2'b10));

    // Line C: line_start while busy, then reset during the AT fetch.
    start_line(9'd0, 8'd0, 8'd0, 2'd0, 1'b0, 3'd0);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    chk("ovr_flag", 32'({overrun, mem_req, busy}), 32'(3'b111));
    chk("ovr_addr", 32'(mem_addr), 32'h2000);
    fetch("c_nt", 16'h2000, 8'h05, 0);
    chk("c_at_addr", 32'({mem_req, mem_addr}), 32'({1'b1, 16'h23C0}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("c_rst", 32'({mem_req, busy, overrun, mem_addr, tile_valid}), 0);

    // Fresh line after reset restarts at the NT fetch.
    start_line(9'd8, 8'd0, 8'd0, 2'd0, 1'b0, 3'd0);
    do_tile("f", 16'h2020, 16'h23C0, 16'h0070, 8'h07, 8'hE4, 8'hAA, 8'h55, 2'd0, 0, 0);
    chk("f_overrun", 32'(overrun), 0);
    abort_line();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
